// File: rtl/mat_vec_stream_ctrl_if.sv
// Valid/ready word streams between mat_vec_stream_ctrl and its operand source / result sink.
interface mat_vec_stream_ctrl_if #(
    parameter int W = 16
) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mat_vec_stream_ctrl.sv
// Serial-to-parallel operand loader and parallel-to-serial result drainer for mat_mul.
module mat_vec_stream_ctrl #(
    parameter int N      = 16,
    parameter int W      = 16,
    parameter int SETTLE = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mat_vec_stream_ctrl_if.slave           strm,
    output logic [N-1:0][N-1:0][W-1:0]     mat1,
    output logic [N-1:0][W-1:0]            mat2,
    output logic [N-1:0][W-1:0]            bias,
    input  logic [N-1:0][W-1:0]            mm_out,
    output logic                           busy
);

    localparam int unsigned TOTAL = N * N + 2 * N;
    localparam int unsigned CW    = $clog2(TOTAL);
    localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] MAT2_BASE   = CW'(N * N);
    localparam logic [CW-1:0] BIAS_BASE   = CW'(N * N + N);
    localparam logic [CW-1:0] LAST_WORD   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] N_CW        = CW'(N);
    localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                word_cnt_q, word_cnt_d;
    logic [SW-1:0]                settle_cnt_q, settle_cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [N-1:0][N-1:0][W-1:0]   mat1_q, mat1_d;
    logic [N-1:0][W-1:0]          mat2_q, mat2_d;
    logic [N-1:0][W-1:0]          bias_q, bias_d;
    logic [N-1:0][W-1:0]          result_q, result_d;
    logic [W-1:0]                 out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;

    logic [IW-1:0] wr_row, wr_col, wr_vec, wr_bias;

    // Word counter decoded into the destination slot of the current operand word
    assign wr_row  = IW'(word_cnt_q / N_CW);
    assign wr_col  = IW'(word_cnt_q % N_CW);
    assign wr_vec  = IW'(word_cnt_q - MAT2_BASE);
    assign wr_bias = IW'(word_cnt_q - BIAS_BASE);

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        settle_cnt_d = settle_cnt_q;
        idx_d        = idx_q;
        mat1_d       = mat1_q;
        mat2_d       = mat2_q;
        bias_d       = bias_q;
        result_d     = result_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            ST_LOAD: begin
                if (strm.in_valid) begin
                    if (word_cnt_q < MAT2_BASE) begin
                        mat1_d[wr_row][wr_col] = strm.in_data;
                    end else if (word_cnt_q < BIAS_BASE) begin
                        mat2_d[wr_vec] = strm.in_data;
                    end else begin
                        bias_d[wr_bias] = strm.in_data;
                    end
                    // Counter clears on the last word; busy stays high through the non-LOAD states
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d   = '0;
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            ST_CAPTURE: begin
                result_d    = mm_out;
                out_data_d  = mm_out[0];
                out_valid_d = 1'b1;
                idx_d       = '0;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (strm.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        word_cnt_d  = '0;
                        state_d     = ST_LOAD;
                    end else begin
                        idx_d      = idx_q + IW'(1);
                        out_data_d = result_q[idx_q + IW'(1)];
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            word_cnt_q   <= '0;
            settle_cnt_q <= '0;
            idx_q        <= '0;
            mat1_q       <= '0;
            mat2_q       <= '0;
            bias_q       <= '0;
            result_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            idx_q        <= idx_d;
            mat1_q       <= mat1_d;
            mat2_q       <= mat2_d;
            bias_q       <= bias_d;
            result_q     <= result_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign strm.in_ready  = (state_q == ST_LOAD);
    assign strm.out_data  = out_data_q;
    assign strm.out_valid = out_valid_q;
    assign mat1           = mat1_q;
    assign mat2           = mat2_q;
    assign bias           = bias_q;
    assign busy           = (state_q != ST_LOAD) || (word_cnt_q != '0);

endmodule

// File: tb/tb_mat_vec_stream_ctrl.sv
// Directed bench for mat_vec_stream_ctrl with a behavioural mat_mul attached to its operand buses.
module tb_mat_vec_stream_ctrl;

    localparam int N     = 16;
    localparam int W     = 16;
    localparam int TOTAL = N * N + 2 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mat_vec_stream_ctrl_if #(.W(W)) bus ();

    logic [N-1:0][N-1:0][W-1:0] mat1;
    logic [N-1:0][W-1:0]        mat2;
    logic [N-1:0][W-1:0]        bias;
    logic [N-1:0][W-1:0]        mm_out;
    logic                       busy;

    mat_vec_stream_ctrl #(.N(N), .W(W), .SETTLE(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .strm   (bus),
        .mat1   (mat1),
        .mat2   (mat2),
        .bias   (bias),
        .mm_out (mm_out),
        .busy   (busy)
    );

    // Reference mat_mul: out = mat1 x mat2 + bias, wrapped to W bits
    logic signed [W-1:0] mm_acc;
    always_comb begin
        mm_out = '0;
        mm_acc = '0;
        for (int i = 0; i < N; i++) begin
            mm_acc = $signed(bias[i]);
            for (int j = 0; j < N; j++) begin
                mm_acc = mm_acc + $signed(mat1[i][j]) * $signed(mat2[j]);
            end
            mm_out[i] = mm_acc;
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] job     [TOTAL];
    logic [W-1:0] exp_res [N];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int count_nonzero();
        int n = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) if (mat1[r][c] != '0) n++;
            if (mat2[r] != '0) n++;
            if (bias[r] != '0) n++;
        end
        return n;
    endfunction

    // kind 0: all zero; 1: identity, mat2=1..N, bias=100; 2: mat1 all 2, mat2 all 1, bias all -1
    task automatic build_job(input int kind);
        for (int k = 0; k < N * N; k++) begin
            case (kind)
                1:       job[k] = ((k / N) == (k % N)) ? 16'd1 : 16'd0;
                2:       job[k] = 16'd2;
                default: job[k] = 16'd0;
            endcase
        end
        for (int i = 0; i < N; i++) begin
            case (kind)
                1: begin
                    job[N*N+i]   = 16'(i + 1);
                    job[N*N+N+i] = 16'd100;
                    exp_res[i]   = 16'(101 + i);
                end
                2: begin
                    job[N*N+i]   = 16'd1;
                    job[N*N+N+i] = 16'hFFFF;
                    exp_res[i]   = 16'd31;
                end
                default: begin
                    job[N*N+i]   = 16'd0;
                    job[N*N+N+i] = 16'd0;
                    exp_res[i]   = 16'd0;
                end
            endcase
        end
    endtask

    // Called at a negedge; returns at the negedge right after the last accepting edge
    task automatic send_words(input int count, input bit gaps);
        int  k = 0;
        int  stall = 0;
        bit  phase = 1'b0;
        bit  acc;
        while (k < count) begin
            bus.in_valid = gaps ? phase : 1'b1;
            bus.in_data  = bus.in_valid ? job[k] : 16'hDEAD;
            phase        = ~phase;
            acc          = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) begin
                k++;
                stall = 0;
                if (k == 1) check_eq("busy_after_first_word", 64'(busy), 64'd1);
            end else begin
                stall++;
                if (stall > 20) begin
                    check_eq("load_words_accepted", 64'(k), 64'(count));
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int exp_lat, input bit offer_junk);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            if (offer_junk) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'h7777;
                check_eq("in_ready_low_settle", 64'(bus.in_ready), 64'd0);
            end
            @(negedge clk);
            n++;
        end
        check_eq("result_latency", 64'(n), 64'(exp_lat));
    endtask

    task automatic recv_results(input bit stall, input bit offer_junk);
        int i = 0;
        int guard = 0;
        int stalls = 0;
        bit tog = 1'b0;
        bit r;
        while (i < N && guard < 400) begin
            if (offer_junk) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'h7777;
                check_eq("in_ready_low_drain", 64'(bus.in_ready), 64'd0);
            end
            check_eq("out_valid_drain", 64'(bus.out_valid), 64'd1);
            check_eq("busy_drain", 64'(busy), 64'd1);
            check_eq($sformatf("result_%0d", i), 64'(bus.out_data), 64'(exp_res[i]));
            if (!stall) begin
                r = 1'b1;
            end else if (stalls < 5) begin
                r = 1'b0;
                stalls++;
            end else begin
                r   = tog;
                tog = ~tog;
            end
            bus.out_ready = r;
            @(negedge clk);
            if (r) i++;
            guard++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq("results_drained", 64'(i), 64'(N));
        check_eq("out_valid_after_drain", 64'(bus.out_valid), 64'd0);
        check_eq("busy_after_drain", 64'(busy), 64'd0);
        check_eq("in_ready_after_drain", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_out_data", 64'(bus.out_data), 64'd0);
        check_eq("reset_operands_zero", 64'(count_nonzero()), 64'd0);

        // All-zero job
        build_job(0);
        send_words(TOTAL, 1'b0);
        wait_out_valid(2, 1'b0);
        recv_results(1'b0, 1'b0);

        // Identity job, with operand placement spot checks
        build_job(1);
        send_words(TOTAL, 1'b0);
        check_eq("mat1_0_0", 64'(mat1[0][0]), 64'd1);
        check_eq("mat1_0_1", 64'(mat1[0][1]), 64'd0);
        check_eq("mat1_15_15", 64'(mat1[15][15]), 64'd1);
        check_eq("mat2_0", 64'(mat2[0]), 64'd1);
        check_eq("mat2_15", 64'(mat2[15]), 64'd16);
        check_eq("bias_0", 64'(bias[0]), 64'd100);
        check_eq("bias_15", 64'(bias[15]), 64'd100);
        wait_out_valid(2, 1'b0);
        recv_results(1'b0, 1'b0);

        // Partial load then asynchronous reset
        build_job(2);
        send_words(100, 1'b0);
        check_eq("partial_mat1_6_3", 64'(mat1[6][3]), 64'd2);
        check_eq("partial_mat1_6_4", 64'(mat1[6][4]), 64'd0);
        check_eq("partial_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("midreset_busy", 64'(busy), 64'd0);
        check_eq("midreset_operands_zero", 64'(count_nonzero()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity job under input gaps and output backpressure
        build_job(1);
        send_words(TOTAL, 1'b1);
        wait_out_valid(2, 1'b0);
        recv_results(1'b1, 1'b0);

        // Back-to-back job with words offered while not in LOAD
        build_job(2);
        send_words(TOTAL, 1'b0);
        wait_out_valid(2, 1'b1);
        recv_results(1'b0, 1'b1);
        check_eq("junk_not_written_mat2_0", 64'(mat2[0]), 64'd1);

        // A further job must start cleanly at word 0
        build_job(1);
        send_words(TOTAL, 1'b0);
        wait_out_valid(2, 1'b0);
        recv_results(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
